// File: rtl/uart_stream_mem_loader.sv
// ============================================================================
//  Module      : uart_stream_mem_loader
//  Description : Packs a valid/ready byte stream little-endian into 32-bit
//                words and writes them to on-chip RAM through Avalon-MM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_stream_mem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    input  logic                  in_eop,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic [3:0]            avm_byteenable,
    output logic                  avm_chipselect,
    output logic                  avm_write,
    output logic [31:0]           avm_writedata,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_written,
    output logic                  overflow
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] c_one   = (ADDR_WIDTH+1)'(1);

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH:0]   r_ptr;
    logic [ADDR_WIDTH:0]   r_words;
    logic [1:0]            r_byte_idx;
    logic [23:0]           r_pack;
    logic                  r_eop_held;
    logic                  r_overflow;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [3:0]            r_be;
    logic [31:0]           r_wdata;

    logic                  w_accept;
    logic                  w_full;
    logic                  w_word_end;
    logic                  w_drop_end;
    logic [31:0]           w_word;
    logic [3:0]            w_be;

    assign w_accept   = in_valid && (r_state == S_COLLECT);
    assign w_full     = (r_ptr == c_depth);
    assign w_word_end = w_accept && !w_full && ((r_byte_idx == 2'd3) || in_eop);
    assign w_drop_end = w_accept && w_full && in_eop;

    // Lanes above the current index are always zero in r_pack, so a short
    // final word carries zeros in its unused lanes.
    always_comb begin
        w_word = {8'h00, r_pack};
        w_be   = 4'b0001;
        case (r_byte_idx)
            2'd0: begin w_word[7:0]   = in_data; w_be = 4'b0001; end
            2'd1: begin w_word[15:8]  = in_data; w_be = 4'b0011; end
            2'd2: begin w_word[23:16] = in_data; w_be = 4'b0111; end
            default: begin w_word[31:24] = in_data; w_be = 4'b1111; end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        in_ready       = 1'b0;
        avm_write      = 1'b0;
        avm_chipselect = 1'b0;
        done           = 1'b0;
        busy           = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                in_ready = 1'b1;
                if (w_word_end) begin
                    w_state_next = S_WRITE;
                end else if (w_drop_end) begin
                    w_state_next = S_DONE;
                end
            end
            S_WRITE: begin
                avm_write      = 1'b1;
                avm_chipselect = 1'b1;
                w_state_next   = r_eop_held ? S_DONE : S_COLLECT;
            end
            default: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr      <= '0;
            r_words    <= '0;
            r_byte_idx <= '0;
            r_pack     <= '0;
            r_eop_held <= 1'b0;
            r_overflow <= 1'b0;
            r_address  <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_ptr      <= '0;
                r_words    <= '0;
                r_byte_idx <= '0;
                r_pack     <= '0;
                r_eop_held <= 1'b0;
                r_overflow <= 1'b0;
            end
            if (w_accept) begin
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else if (w_word_end) begin
                    r_address  <= r_ptr[ADDR_WIDTH-1:0];
                    r_be       <= w_be;
                    r_wdata    <= w_word;
                    r_pack     <= '0;
                    r_eop_held <= in_eop;
                end else begin
                    r_pack     <= w_word[23:0];
                    r_byte_idx <= r_byte_idx + 2'd1;
                end
            end
            if (r_state == S_WRITE) begin
                r_ptr      <= r_ptr + c_one;
                r_byte_idx <= '0;
                if (r_words != c_depth) begin
                    r_words <= r_words + c_one;
                end
            end
        end
    end

    assign avm_address    = r_address;
    assign avm_byteenable = r_be;
    assign avm_writedata  = r_wdata;
    assign words_written  = r_words;
    assign overflow       = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_uart_stream_mem_loader.sv
// ============================================================================
//  Module      : tb_uart_stream_mem_loader
//  Description : Self-checking bench for uart_stream_mem_loader with a
//                packet-level write model and directed packets.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_stream_mem_loader;

    localparam int ADDR_WIDTH = 10;
    localparam int DEPTH      = 1024;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  start = 1'b0;
    logic [7:0]            in_data = 8'h00;
    logic                  in_valid = 1'b0;
    logic                  in_eop = 1'b0;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] avm_address;
    logic [3:0]            avm_byteenable;
    logic                  avm_chipselect;
    logic                  avm_write;
    logic [31:0]           avm_writedata;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH:0]   words_written;
    logic                  overflow;

    uart_stream_mem_loader #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_eop(in_eop), .in_ready(in_ready),
        .avm_address(avm_address), .avm_byteenable(avm_byteenable),
        .avm_chipselect(avm_chipselect), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .busy(busy), .done(done),
        .words_written(words_written), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        logic [3:0]            be;
        logic [31:0]           data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] pkt[$];
    logic [31:0] ram_seen[DEPTH];
    logic [3:0]  be_seen[DEPTH];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wr_count = 0;
    int done_count = 0;
    int last_write_cyc = -1;
    int last_done_cyc = -1;
    int eop_acc_cyc = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Every write the DUT issues must be the next one the packet model predicts.
    always @(negedge clk) begin
        if (reset_n) begin
            check("cs_eq_write", {63'd0, avm_chipselect}, {63'd0, avm_write});
            if (avm_write) begin
                check("ready_in_write", {63'd0, in_ready}, 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", {54'd0, avm_address}, 64'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_addr", {54'd0, avm_address}, {54'd0, e.addr});
                    check("write_be", {60'd0, avm_byteenable}, {60'd0, e.be});
                    check("write_data", {32'd0, avm_writedata}, {32'd0, e.data});
                end
                ram_seen[avm_address] = avm_writedata;
                be_seen[avm_address]  = avm_byteenable;
                wr_count++;
                last_write_cyc = cyc;
            end
            if (done) begin
                done_count++;
                last_done_cyc = cyc;
            end
            if (in_valid && in_ready && in_eop) eop_acc_cyc = cyc + 1;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Send pkt[] as one packet from a fresh start; gap=1 idles valid every other cycle.
    task automatic run_packet(input string name, input bit gap);
        int nwords;
        int i;
        int guard;
        int done_before;
        bit phase;
        logic acc;
        wr_t e;
        nwords = (pkt.size() + 3) / 4;
        for (int w = 0; w < nwords && w < DEPTH; w++) begin
            e.addr = ADDR_WIDTH'(w);
            e.be   = 4'b0000;
            e.data = 32'd0;
            for (int k = 0; k < 4; k++) begin
                if (4*w + k < pkt.size()) begin
                    e.data[8*k +: 8] = pkt[4*w + k];
                    e.be[k] = 1'b1;
                end
            end
            exp_q.push_back(e);
        end
        wr_count    = 0;
        done_before = done_count;
        pulse_start();
        i = 0; guard = 0; phase = 1'b0;
        while (i < pkt.size() && guard < 20 * pkt.size() + 50) begin
            if (gap && phase) begin
                in_valid = 1'b0;
                in_eop   = 1'b0;
            end else begin
                in_data  = pkt[i];
                in_valid = 1'b1;
                in_eop   = (i == pkt.size() - 1);
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            phase = !phase;
            guard++;
        end
        in_valid = 1'b0;
        in_eop   = 1'b0;
        check({name, "_all_bytes_taken"}, 64'(i), 64'(pkt.size()));
        for (int k = 0; k < 20 && busy; k++) begin
            @(posedge clk); #1;
        end
        check({name, "_idle"}, {63'd0, busy}, 64'd0);
        check({name, "_done_pulses"}, 64'(done_count - done_before), 64'd1);
        check({name, "_words_written"}, {53'd0, words_written}, 64'(nwords > DEPTH ? DEPTH : nwords));
        check({name, "_overflow"}, {63'd0, overflow}, {63'd0, pkt.size() > 4*DEPTH});
        check({name, "_writes_pending"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_quiet(input string name);
        check({name, "_ready"}, {63'd0, in_ready}, 64'd0);
        check({name, "_busy"}, {63'd0, busy}, 64'd0);
        check({name, "_done"}, {63'd0, done}, 64'd0);
        check({name, "_wr_cs"}, {62'd0, avm_write, avm_chipselect}, 64'd0);
        check({name, "_addr_be"}, {50'd0, avm_address, avm_byteenable}, 64'd0);
        check({name, "_wdata"}, {32'd0, avm_writedata}, 64'd0);
        check({name, "_words_ovf"}, {52'd0, words_written, overflow}, 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Test 1: two full words
        pkt.delete();
        for (int b = 1; b <= 8; b++) pkt.push_back(8'(b));
        run_packet("t1", 1'b0);
        check("t1_lit_word0", {32'd0, ram_seen[0]}, 64'h0403_0201);
        check("t1_lit_word1", {32'd0, ram_seen[1]}, 64'h0807_0605);
        check("t1_lit_be1", {60'd0, be_seen[1]}, 64'hF);
        check("t1_lit_words", {53'd0, words_written}, 64'd2);

        // Test 2: partial final word
        pkt.delete();
        for (int b = 0; b < 6; b++) pkt.push_back(8'hA0 + 8'(b));
        run_packet("t2", 1'b0);
        check("t2_lit_word1", {32'd0, ram_seen[1]}, 64'h0000_A5A4);
        check("t2_lit_be1", {60'd0, be_seen[1]}, 64'h3);

        // Test 3: single byte packet and its latency
        pkt.delete();
        pkt.push_back(8'h5A);
        run_packet("t3", 1'b0);
        check("t3_lit_word0", {32'd0, ram_seen[0]}, 64'h0000_005A);
        check("t3_lit_be0", {60'd0, be_seen[0]}, 64'h1);
        check("t3_lit_writes", 64'(wr_count), 64'd1);
        check("t3_write_latency", 64'(last_write_cyc), 64'(eop_acc_cyc));
        check("t3_done_latency", 64'(last_done_cyc), 64'(eop_acc_cyc + 1));

        // Test 5: gapped valid gives the same RAM image as test 1
        pkt.delete();
        for (int b = 1; b <= 8; b++) pkt.push_back(8'(b));
        run_packet("t5", 1'b1);
        check("t5_lit_word0", {32'd0, ram_seen[0]}, 64'h0403_0201);
        check("t5_lit_word1", {32'd0, ram_seen[1]}, 64'h0807_0605);

        // Test 4: RAM overflow
        pkt.delete();
        for (int b = 0; b < 4100; b++) pkt.push_back(8'(b * 7 + 3));
        run_packet("t4", 1'b0);
        check("t4_lit_writes", 64'(wr_count), 64'd1024);
        check("t4_lit_overflow", {63'd0, overflow}, 64'd1);
        check("t4_lit_words", {53'd0, words_written}, 64'd1024);

        // Test 6: reset asserted inside a write cycle
        pulse_start();
        for (int b = 0; b < 4; b++) begin
            in_data  = 8'hC0 + 8'(b);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("t6_in_write", {63'd0, avm_write}, 64'd1);
        reset_n = 1'b0;
        #1;
        check("t6_write_drop", {62'd0, avm_write, avm_chipselect}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        in_data  = 8'h77;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check_quiet("t6_post");
        end
        in_valid = 1'b0;
        pkt.delete();
        pkt.push_back(8'h11);
        pkt.push_back(8'h22);
        run_packet("t6_restart", 1'b0);
        check("t6_lit_word0", {32'd0, ram_seen[0]}, 64'h0000_2211);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
